// File: rtl/byte_serial_pkg.sv
// Shared definitions for the byte-lane serial transmitter.
//
// Contents:
//   bstx_state_t        transmitter FSM state encoding
//   BSTX_DEFAULT_WIDTH  default data word width in bits
package byte_serial_pkg;

    // PARITY is only reachable when BYTE_SERIAL_TX_PARITY_EN is defined, but the
    // encoding is kept identical in both builds.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } bstx_state_t;

    localparam int unsigned BSTX_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bstx_bit_cnt.sv
// Bit-index counter for byte_serial_tx.
//
// Counts beats within a word. It is cleared when a word is captured and steps
// once per accepted beat. It saturates at WIDTH-1, so it never wraps.
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset (count returns to 0)
//   clr    synchronous clear, has priority over en
//   en     advance by one (ignored once terminal count is reached)
//   cnt    current bit index, $clog2(WIDTH) bits
//   tc     terminal count, high when cnt == WIDTH-1
module bstx_bit_cnt
    import byte_serial_pkg::*;
#(
    parameter int unsigned WIDTH = BSTX_DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     tc
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastIdx = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LastIdx)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LastIdx);

endmodule

// File: rtl/byte_serial_tx.sv
// Bit-serial transmitter for [0:WIDTH-1] ascending-index words.
//
// Captures one parallel word while idle. It then sends the word one bit per
// accepted beat, starting with index 0. The final beat of the word is flagged
// with sout_last. All outputs are decoded from registered state only.
//
// Build option:
//   BYTE_SERIAL_TX_PARITY_EN  when defined, one even-parity beat (XOR of the
//                             captured word) follows bit WIDTH-1 and carries
//                             sout_last instead of bit WIDTH-1.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset; discards any word in flight
//   din         parallel word, index 0 transmitted first
//   din_valid   din holds a word to send
//   din_ready   word can be captured this cycle (high only in IDLE)
//   sout        current serial bit
//   sout_valid  sout is meaningful
//   sout_last   current beat is the final beat of the word
//   sout_ready  sink accepts the current beat
module byte_serial_tx
    import byte_serial_pkg::*;
#(
    parameter int unsigned WIDTH = BSTX_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [0:WIDTH-1] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    input  logic             sout_ready
);

    localparam int unsigned CW = $clog2(WIDTH);

    bstx_state_t      state_q;
    bstx_state_t      state_d;
    logic [0:WIDTH-1] sreg_q;
    logic [0:WIDTH-1] sreg_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic [CW-1:0]    cnt;
    logic             cnt_tc;

    bstx_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    // Next-state logic. The shift register is loaded as a whole word on capture
    // only. The bit to send is selected by cnt, so sreg is never shifted in place.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (din_valid) begin
                    sreg_d  = din;
                    cnt_clr = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (sout_ready) begin
                    if (cnt_tc) begin
`ifdef BYTE_SERIAL_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            PARITY: begin
                // Unreachable without the parity option; fall back to IDLE.
`ifdef BYTE_SERIAL_TX_PARITY_EN
                if (sout_ready) begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
        end
    end

    // Output decode. Only state_q, sreg_q and the counter feed these outputs, so
    // there is no combinational path from din_valid or sout_ready.
    always_comb begin
        din_ready  = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        sout_last  = 1'b0;

        unique case (state_q)
            IDLE: begin
                din_ready = 1'b1;
            end
            SHIFT: begin
                sout_valid = 1'b1;
                sout       = sreg_q[cnt];
`ifndef BYTE_SERIAL_TX_PARITY_EN
                sout_last  = cnt_tc;
`endif
            end
            PARITY: begin
`ifdef BYTE_SERIAL_TX_PARITY_EN
                sout_valid = 1'b1;
                sout       = ^sreg_q;
                sout_last  = 1'b1;
`endif
            end
            default: begin
                din_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_byte_serial_tx.sv
// Scoreboard bench for byte_serial_tx (WIDTH=8 main instance, WIDTH=2 corner instance).
module tb_byte_serial_tx;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [0:W-1] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         sout;
    logic         sout_valid;
    logic         sout_last;
    logic         sout_ready = 1'b0;

    logic [0:1]   din2 = '0;
    logic         din_valid2 = 1'b0;
    logic         din_ready2;
    logic         sout2;
    logic         sout_valid2;
    logic         sout_last2;

    always #5 clk = ~clk;

    byte_serial_tx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_last  (sout_last),
        .sout_ready (sout_ready)
    );

    byte_serial_tx #(.WIDTH(2)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din2),
        .din_valid  (din_valid2),
        .din_ready  (din_ready2),
        .sout       (sout2),
        .sout_valid (sout_valid2),
        .sout_last  (sout_last2),
        .sout_ready (1'b1)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word becomes a list of beats {bit, final}.
    typedef struct packed {
        logic b;
        logic fin;
    } beat_t;

    beat_t exp_q[$];
    bit    busy = 1'b0;     // a word is in flight, as seen by the model
    bit    prev_stall = 1'b0;
    logic  prev_sout;
    logic  prev_last;

    function automatic void model_push(input logic [0:W-1] w);
        for (int i = 0; i < int'(W); i++) begin
`ifdef BYTE_SERIAL_TX_PARITY_EN
            exp_q.push_back('{b: w[i], fin: 1'b0});
`else
            exp_q.push_back('{b: w[i], fin: (i == int'(W) - 1)});
`endif
        end
`ifdef BYTE_SERIAL_TX_PARITY_EN
        // Even parity: 1 when the word has an odd number of ones.
        begin
            int ones = 0;
            for (int i = 0; i < int'(W); i++) ones += int'(w[i]);
            exp_q.push_back('{b: logic'(ones % 2), fin: 1'b1});
        end
`endif
    endfunction

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        beat_t e;
        chk("din_ready", din_ready, !busy);
        chk("sout_valid", sout_valid, busy);
        if (prev_stall && rst_n) begin
            chk("stall_sout_hold", sout, prev_sout);
            chk("stall_last_hold", sout_last, prev_last);
        end
        prev_stall = sout_valid && !sout_ready && rst_n;
        prev_sout  = sout;
        prev_last  = sout_last;
        if (rst_n && sout_valid && sout_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sout", sout, e.b);
                chk("sout_last", sout_last, e.fin);
                if (e.fin) busy = 1'b0;
            end
        end else if (rst_n && din_valid && !busy) begin
            model_push(din);
            busy = 1'b1;
        end
    end

    bit rand_rdy = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) sout_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Present a word until captured; junk=1 keeps din_valid high with random
    // data afterwards to show that it is ignored while busy.
    task automatic send(input logic [0:W-1] w, input bit junk);
        int t = 0;
        din       = w;
        din_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (din_ready) begin
                tick();
                din_valid = junk;
                din       = W'($urandom);
                break;
            end
            tick();
            t++;
            if (t > 200) begin
                chk("capture_timeout", 0, 1);
                din_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy || exp_q.size() != 0) begin
            tick();
            t++;
            if (t > 500) begin
                chk("drain_timeout", 0, 1);
                exp_q.delete();
                busy = 1'b0;
                break;
            end
        end
        din_valid = 1'b0;
        tick();
    endtask

`ifdef BYTE_SERIAL_TX_PARITY_EN
    localparam int N2 = 7;
    logic [0:N2-1] v2_exp = 7'b1110111;
    logic [0:N2-1] s2_exp = 7'b1010011;
    logic [0:N2-1] l2_exp = 7'b0010001;
`else
    localparam int N2 = 5;
    logic [0:N2-1] v2_exp = 5'b11011;
    logic [0:N2-1] s2_exp = 5'b10001;
    logic [0:N2-1] l2_exp = 5'b01001;
`endif

    initial begin
        // Reset state.
        #2;
        chk("rst_din_ready", din_ready, 1);
        chk("rst_sout_valid", sout_valid, 0);
        chk("rst_sout", sout, 0);
        chk("rst_sout_last", sout_last, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Directed word, sink always ready.
        sout_ready = 1'b1;
        send(8'b1011_0001, 1'b0);
        wait_idle();

        // Backpressure on bit 4: 3 stall cycles.
        send(8'b1011_0001, 1'b0);
        repeat (4) tick();
        chk("bp_bit4", sout, 0);
        sout_ready = 1'b0;
        repeat (3) tick();
        chk("bp_bit4_held", sout, 0);
        sout_ready = 1'b1;
        wait_idle();

        // Ignored input: din=FF with din_valid during SHIFT.
        send(8'b1011_0001, 1'b0);
        tick();
        din = 8'hFF;
        din_valid = 1'b1;
        wait_idle();

        // Parity-oriented word (plain data beats in the default build).
        send(8'b1110_0000, 1'b0);
        wait_idle();

        // Reset during the third bit.
        send(8'b1011_0001, 1'b0);
        repeat (2) tick();
        chk("pre_rst_valid", sout_valid, 1);
        rst_n = 1'b0;
        exp_q.delete();
        busy = 1'b0;
        prev_stall = 1'b0;
        #1;
        chk("async_rst_valid", sout_valid, 0);
        chk("async_rst_ready", din_ready, 1);
        chk("async_rst_last", sout_last, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (W + 4) tick();

        // Randomised words with random backpressure and junk input while busy.
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send(W'($urandom), bit'($urandom_range(0, 1)));
            din_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle();
        rand_rdy = 1'b0;
        sout_ready = 1'b1;

        // WIDTH=2, back-to-back words 1,0 then 0,1.
        din2 = 2'b10;
        din_valid2 = 1'b1;
        @(negedge clk);
        chk("w2_idle_ready", din_ready2, 1);
        tick();
        din2 = 2'b01;
        for (int k = 0; k < N2; k++) begin
            logic [0:N2-1] v, s, l;
            v = v2_exp;
            s = s2_exp;
            l = l2_exp;
            @(negedge clk);
            chk("w2_valid", sout_valid2, v[k]);
            chk("w2_ready", din_ready2, !v[k]);
            if (v[k]) begin
                chk("w2_sout", sout2, s[k]);
                chk("w2_last", sout_last2, l[k]);
            end
            tick();
            if (!v[k]) din_valid2 = 1'b0;
        end
        @(negedge clk);
        chk("w2_done_valid", sout_valid2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
